// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier, unsigned or two's-complement per operation.
// One add/shift iteration per clock, start/busy/done handshake, optional early exit.
module seq_mult_param #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] mplier_shift_c;
    logic             last_iter_c;

    // Magnitudes in signed mode; the most negative value maps onto its unsigned magnitude.
    always_comb begin
        a_mag_c        = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag_c        = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        mplier_shift_c = mplier_q >> 1;
        last_iter_c    = (cnt_q == CW'(WIDTH - 1)) ||
                         (EARLY_EXIT && (mplier_shift_c == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (last_iter_c) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; everything holds unless the current state updates it.
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    mcand_d  = PW'(a_mag_c);
                    mplier_d = b_mag_c;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift_c;
                cnt_d    = cnt_q + CW'(1);
            end
            ST_FIN: begin
                product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: three instances (8-bit fixed, 8-bit early exit,
// 13-bit early exit) driven by directed and random operations against an arithmetic model.
module tb_seq_mult_param;

    typedef struct {
        int     id;
        longint prod;
        longint edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic        sm_v    [3];
    logic [12:0] a_v     [3];
    logic [12:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [25:0] prod_v  [3];

    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [15:0] p0, p1;
    logic [25:0] p2;

    exp_t   sb_q[$];
    longint cyc   = 0;
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy0), .done(done0), .product(p0));

    seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy1), .done(done1), .product(p1));

    seq_mult_param #(.WIDTH(13), .EARLY_EXIT(1'b1)) u_w13e (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy2), .done(done2), .product(p2));

    always_comb begin
        busy_v[0] = busy0;  busy_v[1] = busy1;  busy_v[2] = busy2;
        done_v[0] = done0;  done_v[1] = done1;  done_v[2] = done2;
        prod_v[0] = {10'd0, p0};
        prod_v[1] = {10'd0, p1};
        prod_v[2] = p2;
    end

    function automatic int w_of(input int id);
        return (id == 2) ? 13 : 8;
    endfunction

    function automatic bit ee_of(input int id);
        return id != 0;
    endfunction

    // Reference: interpret operands as numbers, multiply, wrap to 2*w bits.
    function automatic longint ref_prod(input int w, input bit s, input longint av, input longint bv);
        longint m, ua, ub, sa, sb;
        m  = (longint'(1) << w) - 1;
        ua = av & m;
        ub = bv & m;
        sa = (s && ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (s && ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Iterations: w in fixed mode, else index of highest set bit of |b| plus one (at least 1).
    function automatic int ref_iters(input int w, input bit ee, input bit s, input longint bv);
        longint m, ub, mag;
        int n;
        m   = (longint'(1) << w) - 1;
        ub  = bv & m;
        mag = (s && ub >= (longint'(1) << (w - 1))) ? (longint'(1) << w) - ub : ub;
        if (!ee) return w;
        n = 1;
        for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
        return n;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge after the done edge.
    task automatic do_op(input int id, input bit smv, input logic [12:0] av, input logic [12:0] bv,
                         input bit noisy, input int gap);
        exp_t e;
        int   n;
        if (gap > 0) begin
            start_v[id] = 1'b0;
            repeat (gap) @(negedge clk);
        end
        start_v[id] = 1'b1;
        sm_v[id]    = smv;
        a_v[id]     = av;
        b_v[id]     = bv;
        n        = ref_iters(w_of(id), ee_of(id), smv, longint'(bv));
        e.id     = id;
        e.prod   = ref_prod(w_of(id), smv, longint'(av), longint'(bv));
        e.edge_n = cyc + 1 + n + 1;
        sb_q.push_back(e);
        @(negedge clk);
        for (int k = 0; k <= n; k++) begin
            chk($sformatf("busy_high%0d", id), longint'(busy_v[id]), 1);
            if (noisy) begin
                start_v[id] = 1'($urandom);
                sm_v[id]    = 1'($urandom);
                a_v[id]     = 13'($urandom);
                b_v[id]     = 13'($urandom);
            end else begin
                start_v[id] = 1'b0;
            end
            @(negedge clk);
        end
        chk($sformatf("busy_low%0d", id), longint'(busy_v[id]), 0);
        start_v[id] = 1'b0;
    endtask

    task automatic rand_ops(input int id, input int count);
        logic [12:0] av, bv;
        for (int i = 0; i < count; i++) begin
            av = 13'($urandom);
            case ($urandom_range(0, 5))
                0:       bv = '0;
                1:       bv = 13'(1) << (w_of(id) - 1);
                2:       bv = 13'(1);
                default: bv = 13'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) av = '0;
            do_op(id, 1'($urandom), av, bv, 1'b1,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation for that instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] === 1'b1) begin
                int idx;
                idx = -1;
                foreach (sb_q[k]) if (idx < 0 && sb_q[k].id == i) idx = k;
                if (idx < 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done%0d: got done=1 expected no pending op at t=%0t", i, $time);
                end else begin
                    chk($sformatf("product%0d", i), longint'(prod_v[i]), sb_q[idx].prod);
                    chk($sformatf("done_edge%0d", i), cyc, sb_q[idx].edge_n);
                    sb_q.delete(idx);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; sm_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), longint'(busy_v[i]), 0);
            chk($sformatf("rst_done%0d", i), longint'(done_v[i]), 0);
            chk($sformatf("rst_prod%0d", i), longint'(prod_v[i]), 0);
        end

        // Fixed-latency 8-bit corner cases.
        do_op(0, 1'b0, 13'h0FF, 13'h0FF, 1'b0, 0);
        chk("u255x255", longint'(prod_v[0]), 'hFE01);
        @(negedge clk);
        chk("done_single_pulse", longint'(done_v[0]), 0);
        do_op(0, 1'b1, 13'h0FD, 13'h005, 1'b0, 1);
        chk("s_m3x5", longint'(prod_v[0]), 'hFFF1);
        do_op(0, 1'b1, 13'h080, 13'h080, 1'b0, 1);
        chk("s_m128xm128", longint'(prod_v[0]), 'h4000);
        do_op(0, 1'b0, 13'h080, 13'h080, 1'b0, 1);
        chk("u128x128", longint'(prod_v[0]), 'h4000);

        // Start held high, inputs toggling while busy.
        for (int i = 0; i < 4; i++) do_op(0, 1'($urandom), 13'($urandom), 13'($urandom), 1'b1, 0);

        // Asynchronous reset in the fourth CALC cycle aborts the operation.
        @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b0; a_v[0] = 13'h0AB; b_v[0] = 13'h0CD;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", longint'(busy_v[0]), 0);
        chk("abort_done", longint'(done_v[0]), 0);
        chk("abort_prod", longint'(prod_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done_v[0]) saw = 1'b1;
        end
        chk("no_done_after_abort", longint'(saw), 0);
        do_op(0, 1'b0, 13'h00C, 13'h00B, 1'b0, 0);
        chk("after_abort", longint'(prod_v[0]), 'h0084);

        // Early exit latencies.
        do_op(1, 1'b0, 13'h0C8, 13'h000, 1'b0, 0);
        chk("ee_b0", longint'(prod_v[1]), 0);
        do_op(1, 1'b0, 13'h0C8, 13'h001, 1'b0, 1);
        chk("ee_b1", longint'(prod_v[1]), 200);
        do_op(1, 1'b0, 13'h003, 13'h080, 1'b0, 1);
        chk("ee_b80", longint'(prod_v[1]), 'h0180);

        fork
            rand_ops(0, 350);
            rand_ops(1, 350);
            rand_ops(2, 350);
        join

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", longint'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
